// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the convolution window generator.
//   conv_win_state_t : frame sequencing state (FILL, RUN, LAST)
//   conv_out_size()  : side of the valid-convolution output map
//   coord_width()    : bit width of an output coordinate (at least 1)
package conv_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,   // first K-1 rows: loading line buffers only
        RUN  = 2'd1,   // windows being produced
        LAST = 2'd2    // final pixel taken, waiting for last window to drain
    } conv_win_state_t;

    function automatic int conv_out_size(input int in_size, input int k_size);
        return in_size - (k_size - 1);
    endfunction

    function automatic int coord_width(input int out_size);
        return (out_size > 1) ? $clog2(out_size) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of delay.
//   On a write cycle the word stored at addr (written one row earlier) is
//   presented on rd_data while the new word replaces it, so rd_data is the
//   pixel directly above the one being written.
// Ports:
//   clk      rising-edge clock
//   wr_en    accept strobe; memory only changes when set
//   addr     column index of the current pixel
//   wr_data  pixel entering this row delay
//   rd_data  pixel one row above (combinational read of the old contents)
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    // Contents are never reset: rows are always rewritten before they can
    // reach an emitted window.
    logic [W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK convolution window producer.
//   Takes one raster-order pixel per handshake, keeps K-1 previous rows in
//   chained line buffers and a KxK shift window, and presents every fully
//   populated window on a one-deep registered output.
//   out_window[k][j] = img[out_x + k][out_y + j].
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   pixel handshake; in_px is one pixel (C samples)
//   out_valid/out_ready window handshake
//   out_window          KxKxC window
//   out_x, out_y        window origin (row, column)
//   frame_done          high during the handshake of window (OS-1, OS-1)
//   stall_cnt           only with CONV_WIN_STALL_CNT_EN: cycles spent with
//                       out_valid && !out_ready, saturating, cleared by rst
// Configuration macro: CONV_WIN_STALL_CNT_EN (adds stall_cnt port/counter).
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int  INPUT_SIZE     = 32,
    parameter int  INPUT_CHANNELS = 3,
    parameter int  KERNEL_SIZE    = 3,
    parameter int  PX_SIZE        = 8,
    localparam int OUTPUT_SIZE    = conv_out_size(INPUT_SIZE, KERNEL_SIZE),
    localparam int CW             = coord_width(OUTPUT_SIZE)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] in_px,
    output logic out_valid,
    input  logic out_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] out_window,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic frame_done
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int K   = KERNEL_SIZE;
    localparam int C   = INPUT_CHANNELS;
    localparam int PX  = PX_SIZE;
    localparam int CLW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    // Row counter can briefly hold INPUT_SIZE after the final pixel.
    localparam int RW  = $clog2(INPUT_SIZE + 1);

    localparam logic [CLW-1:0] COL_MAX = CLW'(INPUT_SIZE - 1);
    localparam logic [RW-1:0]  ROW_MAX = RW'(INPUT_SIZE - 1);
    localparam logic [CLW-1:0] COL_K1  = CLW'(K - 1);
    localparam logic [RW-1:0]  ROW_K1  = RW'(K - 1);

    typedef logic [C-1:0][PX-1:0] px_t;
    typedef logic [K-1:0][K-1:0][C-1:0][PX-1:0] win_t;

    conv_win_state_t state;
    logic [RW-1:0]   row;
    logic [CLW-1:0]  col;

    logic accept;
    logic emit;
    logic produce;
    logic last_px;

    // col_vec[k] is the pixel of image row (row-(K-1)+k) at the current
    // column: the incoming pixel is the bottom row, each line buffer stage
    // reaches one row further up.
    px_t  col_vec [K];
    win_t win_nxt;

    assign accept     = in_valid && in_ready;
    assign emit       = out_valid && out_ready;
    assign produce    = accept && (row >= ROW_K1) && (col >= COL_K1);
    assign last_px    = accept && (row == ROW_MAX) && (col == COL_MAX);
    assign frame_done = emit && (state == LAST);

    // One-deep output register: accept whenever the slot is empty or being
    // drained this cycle; stop entirely while the final window is pending.
    assign in_ready = !rst && (state != LAST) && (!out_valid || out_ready);

    assign col_vec[K-1] = in_px;

    if (K > 1) begin : g_lb
        for (genvar i = 0; i < K - 1; i++) begin : g_stage
            conv_line_buffer #(
                .DEPTH (INPUT_SIZE),
                .AW    (CLW),
                .W     (C * PX)
            ) u_lb (
                .clk     (clk),
                .wr_en   (accept),
                .addr    (col),
                .wr_data (col_vec[K-1-i]),
                .rd_data (col_vec[K-2-i])
            );
        end
    end

    // Shift the window one column left and insert the new column on the
    // right. Windows straddling a row wrap are built here too but are never
    // flagged valid; K-1 more shifts flush them.
    always_comb begin
        win_nxt = out_window;
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_nxt[k][j] = out_window[k][j+1];
            end
            win_nxt[k][K-1] = col_vec[k];
        end
    end

    // Window data needs no reset: it is only observed once out_valid is set,
    // which requires K full columns to have been shifted in after reset.
    // Nothing shifts while a window is stalled because in_ready is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_window <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (last_px) begin
                    state <= LAST;
                end else if (row >= ROW_K1) begin
                    state <= RUN;
                end

                if (produce) begin
                    out_x <= CW'(row - ROW_K1);
                    out_y <= CW'(col - COL_K1);
                end
            end

            // A new window overwrites the slot in the same cycle the old one
            // is taken, so an unstalled stream has no bubbles.
            if (produce) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Final window taken: frame closed, next frame may start at once.
            if (frame_done) begin
                state <= FILL;
                row   <= '0;
                col   <= '0;
            end
        end
    end

`ifdef CONV_WIN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
